spi_reg_decoder: RTL

Downstream consumer of the SPI slave's received-byte stream, running in the clk domain. Parses each chip-select frame as a command byte followed by data bytes, and writes or reads an internal bank of 8-bit registers with address auto-increment. Register 0 drives the board LEDs. Read data is staged on a tx byte interface for the future MISO transmitter.

---
 rtl/spi_reg_pkg.sv | 21 ++
 rtl/spi_reg_decoder_sync_ff.sv | 33 +++
 rtl/spi_reg_decoder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register decoder: byte/address widths,
// command-byte layout and the frame state encoding.
package spi_reg_pkg;

  localparam int BYTE_W     = 8;
  localparam int ADDR_W     = 7;
  localparam int CMD_WR_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  // Register address following a, wrapping 127 -> 0.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/spi_reg_decoder_sync_ff.sv
// Parameterised-depth single-bit synchronizer for asynchronous inputs.
// The reset value is selectable so an idle-high signal such as chip select
// reads as inactive while reset is held.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage further down the chain each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer flops, forced to the inactive value while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_reg_decoder.sv
// Frame decoder for the SPI slave byte stream: a command byte selects
// read/write and a start address, following bytes write or read a bank of
// 8-bit registers with address auto-increment. Register 0 drives the LEDs.
module spi_reg_decoder
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS       = 16,
  parameter int CS_SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BYTE_W-1:0]        rx_data,
  input  logic                     rx_valid,
  input  logic                     cs,
  output logic [BYTE_W-1:0]        led,
  output logic [NUM_REGS*8-1:0]    regs_flat,
  output logic                     wr_strobe,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [BYTE_W-1:0]        wr_data,
  output logic [BYTE_W-1:0]        tx_data,
  output logic                     tx_load,
  output logic                     err,
  output logic                     frame_active
);

  // Register count widened to compare against a zero-extended address.
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic rst_int_n;
  logic cs_s;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0] regs_q [NUM_REGS];
  logic [BYTE_W-1:0] regs_d [NUM_REGS];
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0] wr_data_q, wr_data_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_load_q, tx_load_d;
  logic              err_q, err_d;

  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [BYTE_W-1:0] rd_byte;

  // Reset asserts immediately but releases synchronously to clk.
  sync_ff #(
    .STAGES    (2),
    .RESET_VAL (1'b0)
  ) u_rst_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (rst_int_n)
  );

  // Chip select is asynchronous to clk; only the synchronized copy is used.
  sync_ff #(
    .STAGES    (CS_SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cs),
    .q     (cs_s)
  );

  // Frame parsing: next state, address counter, register writes and reads.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    tx_data_d   = tx_data_q;
    tx_load_d   = 1'b0;
    err_d       = err_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = addr_q;
    rd_byte     = '0;

    case (state_q)
      ST_IDLE: begin
        if (!cs_s) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (rx_valid) begin
          addr_d = rx_data[ADDR_W-1:0];
          if (rx_data[CMD_WR_BIT]) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
            rd_en   = 1'b1;
            rd_addr = rx_data[ADDR_W-1:0];
          end
        end
      end
      ST_WRITE: begin
        if (rx_valid) begin
          wr_en  = 1'b1;
          addr_d = next_addr(addr_q);
        end
      end
      ST_READ: begin
        if (rx_valid) begin
          addr_d  = next_addr(addr_q);
          rd_en   = 1'b1;
          rd_addr = next_addr(addr_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_en) begin
      if ({1'b0, addr_q} < NUM_REGS_W) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (addr_q == ADDR_W'(i)) regs_d[i] = rx_data;
        end
        wr_strobe_d = 1'b1;
        wr_addr_d   = addr_q;
        wr_data_d   = rx_data;
      end else begin
        err_d = 1'b1;
      end
    end

    if (rd_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_addr == ADDR_W'(i)) rd_byte = regs_q[i];
      end
      tx_load_d = 1'b1;
      tx_data_d = rd_byte;
      if (!({1'b0, rd_addr} < NUM_REGS_W)) err_d = 1'b1;
    end

    if (cs_s) state_d = ST_IDLE;
  end

  // State, register bank and registered outputs.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      tx_data_q   <= '0;
      tx_load_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      tx_data_q   <= tx_data_d;
      tx_load_q   <= tx_load_d;
      err_q       <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs_q[g];
  end

  assign led          = regs_q[0];
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign tx_data      = tx_data_q;
  assign tx_load      = tx_load_q;
  assign err          = err_q;
  assign frame_active = (state_q != ST_IDLE);

endmodule
